// File: rtl/sda_link_arbiter_tx.sv
`timescale 1ns/1ps
// sda_link_arbiter_tx: grants one of NREQ requesters and serialises its 4-bit code on scl/sda.
// Build option SDA_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module sda_link_arbiter_tx #(
  parameter int NREQ   = 4,
  parameter int CLKDIV = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NREQ-1:0]                          req,
  input  logic [4*NREQ-1:0]                        din,
  output logic [NREQ-1:0]                          gnt,
  output logic [((NREQ > 2) ? $clog2(NREQ) : 1)-1:0] cur_id,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     scl,
  output logic                                     sda
);

  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int TW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      ph_q, ph_d;
  logic [1:0]      bit_q, bit_d;
  logic [3:0]      code_q, code_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;

  logic            found;
  logic [IDW-1:0]  win;

`ifdef SDA_ARB_RR_EN
  logic [IDW-1:0]  ptr_q, ptr_d;
  int unsigned     idx;

  // Search wraps from the pointer; the first set request at or after it wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && found) ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[IDW'(k)]) begin
        found = 1'b1;
        win   = IDW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    code_d  = code_q;
    id_d    = id_q;
    gnt_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          code_d     = din[{win, 2'b00} +: 4];
          id_d       = win;
          gnt_d[win] = 1'b1;
        end
      end
      ST_GRANT: begin
        state_d = ST_START;
        ph_d    = '0;
        tmr_d   = '0;
      end
      default: begin
        if (tmr_q == TMAX) begin
          tmr_d = '0;
          ph_d  = ph_q + 2'd1;
          case (state_q)
            ST_START: if (ph_q == 2'd1) begin
              state_d = ST_BITS;
              ph_d    = '0;
              bit_d   = 2'd3;
            end
            ST_BITS: if (ph_q == 2'd3) begin
              ph_d = '0;
              if (bit_q == 2'd0) state_d = ST_STOP;
              else               bit_d   = bit_q - 2'd1;
            end
            ST_STOP: if (ph_q == 2'd2) begin
              state_d = ST_GAP;
              ph_d    = '0;
            end
            ST_GAP: if (ph_q == 2'd1) begin
              state_d = ST_IDLE;
              ph_d    = '0;
            end
            default: ;
          endcase
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    endcase

    // Pin levels are decoded from the next phase so the registers update exactly at phase starts.
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      ST_START: begin
        scl_d = (ph_d == 2'd0);
        sda_d = 1'b0;
      end
      ST_BITS: begin
        scl_d = (ph_d == 2'd1) || (ph_d == 2'd2);
        sda_d = code_q[bit_d];
      end
      ST_STOP: begin
        scl_d = (ph_d != 2'd0);
        sda_d = (ph_d == 2'd2);
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_GAP) && (ph_d == 2'd1) && (tmr_d == TMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      code_q  <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign gnt    = gnt_q;
  assign cur_id = id_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign scl    = scl_q;
  assign sda    = sda_q;

endmodule
